// File: rtl/stream_pkg.sv
// Shared types for the stream steering blocks.
// State encoding mirrors the buffer occupancy flags {main_v, skid_v}.
package stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_e;

    localparam int STREAM_SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Generic two-entry (main + skid) valid/ready buffer; output valid one cycle after accept.
// Upstream ready is a pure register (low only while skid is occupied), so it never sees downstream ready.
module stream_skid_buf
    import stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    state_e        r_state;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_acc;
    logic          w_fire;

    assign in_ready_o  = ~r_state[0];
    assign out_valid_o = r_state[1];
    assign out_data_o  = r_main;
    assign w_acc       = in_valid_i && in_ready_o;
    assign w_fire      = out_valid_o && out_ready_i;

    // Payload registers are not reset: only the state flags qualify them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_main  <= in_data_i;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_acc && w_fire) begin
                        r_main <= in_data_i;
                    end else if (w_fire) begin
                        r_state <= EMPTY;
                    end else if (w_acc) begin
                        r_skid  <= in_data_i;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_fire) begin
                        r_main  <= r_skid;
                        r_state <= BUSY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    a_no_accept_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_acc && r_state == FULL));

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N demux: each accepted beat appears on its selected channel one cycle later.
// in_ready_o drops only while the skid entry is held; out-of-range selects are accepted and dropped.
module stream_demux
    import stream_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_OUTPUTS = 8,
    parameter int SELECT_BITS = $clog2(NUM_OUTPUTS),
    parameter int CNT_BITS    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       in_data_i,
    input  logic [SELECT_BITS-1:0] in_sel_i,
    output logic [NUM_OUTPUTS-1:0] out_valid_o,
    input  logic [NUM_OUTPUTS-1:0] out_ready_i,
    output logic [WIDTH-1:0]       out_data_o,
    output logic                   drop_o,
    output logic [CNT_BITS-1:0]    drop_cnt_o
);

    // Field widths follow this instance's parameters, so the beat type lives here.
    typedef struct packed {
        logic [WIDTH-1:0]       data;
        logic [SELECT_BITS-1:0] idx;
    } stream_beat_t;

    stream_beat_t            w_in_beat;
    stream_beat_t            w_main_beat;
    logic                    w_in_range;
    logic                    w_buf_in_valid;
    logic                    w_main_v;
    logic                    w_out_fire;
    logic                    w_drop;
    logic [NUM_OUTPUTS-1:0]  w_out_valid;
    logic                    r_drop;
    logic [CNT_BITS-1:0]     r_drop_cnt;

    // Widened compare so the check stays meaningful when NUM_OUTPUTS is a power of two.
    assign w_in_range     = {1'b0, in_sel_i} < (SELECT_BITS+1)'(NUM_OUTPUTS);
    assign w_in_beat      = '{data: in_data_i, idx: in_sel_i};
    assign w_buf_in_valid = in_valid_i && w_in_range;
    assign w_drop         = in_valid_i && in_ready_o && !w_in_range;

    stream_skid_buf #(
        .DW ($bits(stream_beat_t))
    ) u_skid_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (w_buf_in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (w_in_beat),
        .out_valid_o (w_main_v),
        .out_ready_i (w_out_fire),
        .out_data_o  (w_main_beat)
    );

    always_comb begin
        w_out_valid = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            w_out_valid[k] = w_main_v && (w_main_beat.idx == SELECT_BITS'(k));
        end
    end

    assign w_out_fire  = |(w_out_valid & out_ready_i);
    assign out_valid_o = w_out_valid;
    assign out_data_o  = w_main_beat.data;
    assign drop_o      = r_drop;
    assign drop_cnt_o  = r_drop_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    a_onehot_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(out_valid_o));

    a_stable_under_backpressure: assert property (@(posedge clk_i) disable iff (rst_i)
        (|(out_valid_o & ~out_ready_i)) |=> ($stable(out_valid_o) && $stable(out_data_o)));

endmodule

// File: tb/tb_stream_demux.sv
// Randomized and directed bench for stream_demux: an 8-channel instance and a 5-channel instance
// with a 2-bit drop counter, both checked every cycle against a queue-based reference model.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_in_valid, a_in_ready;
    logic [7:0]  a_in_data;
    logic [2:0]  a_in_sel;
    logic [7:0]  a_out_valid, a_out_ready, a_out_data;
    logic        a_drop;
    logic [15:0] a_drop_cnt;

    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_in_data;
    logic [2:0]  b_in_sel;
    logic [4:0]  b_out_valid, b_out_ready;
    logic [7:0]  b_out_data;
    logic        b_drop;
    logic [1:0]  b_drop_cnt;

    stream_demux #(.WIDTH(8), .NUM_OUTPUTS(8), .CNT_BITS(16)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data), .in_sel_i(a_in_sel),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .drop_o(a_drop), .drop_cnt_o(a_drop_cnt)
    );

    stream_demux #(.WIDTH(8), .NUM_OUTPUTS(5), .CNT_BITS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data), .in_sel_i(b_in_sel),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .drop_o(b_drop), .drop_cnt_o(b_drop_cnt)
    );

    typedef struct {
        logic [2:0] idx;
        logic [7:0] data;
    } beat_t;

    // Reference: each instance is a FIFO of at most two in-flight beats.
    beat_t qa[$];
    beat_t qb[$];
    logic  exp_b_drop;
    int    exp_b_cnt;
    bit    model_ok = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input bit r,
                        input bit av, input logic [2:0] as, input logic [7:0] ad, input logic [7:0] ar,
                        input bit bv, input logic [2:0] bs, input logic [7:0] bd, input logic [4:0] br);
        logic [7:0] ev_a;
        logic [4:0] ev_b;
        bit acc, fire, in_rng;
        @(negedge clk);
        if (model_ok) begin
            ev_a = (qa.size() != 0) ? 8'(8'd1 << qa[0].idx) : 8'd0;
            ev_b = (qb.size() != 0) ? 5'(5'd1 << qb[0].idx) : 5'd0;
            check("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
            check("a_out_valid", 32'(a_out_valid), 32'(ev_a));
            if (qa.size() != 0) check("a_out_data", 32'(a_out_data), 32'(qa[0].data));
            check("a_drop", 32'(a_drop), 32'd0);
            check("a_drop_cnt", 32'(a_drop_cnt), 32'd0);
            check("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
            check("b_out_valid", 32'(b_out_valid), 32'(ev_b));
            if (qb.size() != 0) check("b_out_data", 32'(b_out_data), 32'(qb[0].data));
            check("b_drop", 32'(b_drop), 32'(exp_b_drop));
            check("b_drop_cnt", 32'(b_drop_cnt), 32'(exp_b_cnt));
        end
        rst = r;
        a_in_valid = av; a_in_sel = as; a_in_data = ad; a_out_ready = ar;
        b_in_valid = bv; b_in_sel = bs; b_in_data = bd; b_out_ready = br;
        if (r) begin
            qa.delete();
            qb.delete();
            exp_b_drop = 1'b0;
            exp_b_cnt  = 0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            acc  = av && (qa.size() < 2);
            fire = (qa.size() != 0) && ar[qa[0].idx];
            if (fire) void'(qa.pop_front());
            if (acc) qa.push_back('{idx: as, data: ad});

            acc    = bv && (qb.size() < 2);
            in_rng = (bs < 3'd5);
            fire   = (qb.size() != 0) && br[qb[0].idx];
            if (fire) void'(qb.pop_front());
            if (acc && in_rng) qb.push_back('{idx: bs, data: bd});
            exp_b_drop = acc && !in_rng;
            if (exp_b_drop && exp_b_cnt < 3) exp_b_cnt++;
        end
    endtask

    task automatic idle(input bit r, input logic [7:0] ar, input logic [4:0] br);
        tick(r, 1'b0, 3'd0, 8'd0, ar, 1'b0, 3'd0, 8'd0, br);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0;

        // Reset, then check reset values on the first free cycle.
        idle(1'b1, 8'hFF, 5'h1F);
        idle(1'b1, 8'hFF, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);

        // Full-rate streaming across every channel.
        for (int k = 0; k < 8; k++)
            tick(1'b0, 1'b1, 3'(k), 8'(8'h10 + k), 8'hFF, 1'b0, 3'd0, 8'd0, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);

        // Backpressure on channel 3 with head-of-line blocking behind it.
        tick(1'b0, 1'b1, 3'd3, 8'hA5, 8'hF7, 1'b0, 3'd0, 8'd0, 5'h1F);
        tick(1'b0, 1'b1, 3'd5, 8'h5A, 8'hF7, 1'b0, 3'd0, 8'd0, 5'h1F);
        for (int k = 0; k < 3; k++)
            tick(1'b0, 1'b1, 3'd2, 8'h33, 8'hF7, 1'b0, 3'd0, 8'd0, 5'h1F);
        tick(1'b0, 1'b1, 3'd2, 8'h33, 8'hFF, 1'b0, 3'd0, 8'd0, 5'h1F);
        tick(1'b0, 1'b1, 3'd2, 8'h33, 8'hFF, 1'b0, 3'd0, 8'd0, 5'h1F);
        for (int k = 0; k < 3; k++) idle(1'b0, 8'hFF, 5'h1F);

        // Out-of-range selects on the 5-channel instance; counter saturates at 3.
        tick(1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b1, 3'd6, 8'hEE, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);
        for (int k = 0; k < 5; k++)
            tick(1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b1, 3'(5 + (k % 3)), 8'(k), 5'h1F);
        tick(1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b1, 3'd4, 8'h44, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);
        idle(1'b0, 8'hFF, 5'h1F);

        // Fill main and skid, then reset: buffered beats must vanish.
        tick(1'b0, 1'b1, 3'd1, 8'hC1, 8'h00, 1'b1, 3'd2, 8'hD2, 5'h00);
        tick(1'b0, 1'b1, 3'd4, 8'hC4, 8'h00, 1'b1, 3'd3, 8'hD3, 5'h00);
        idle(1'b0, 8'h00, 5'h00);
        idle(1'b1, 8'hFF, 5'h1F);
        for (int k = 0; k < 4; k++) idle(1'b0, 8'hFF, 5'h1F);

        // Random stress on both instances.
        for (int n = 0; n < 10000; n++)
            tick(1'b0,
                 $urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 8'($urandom | $urandom),
                 $urandom_range(0, 3) != 0, 3'($urandom), 8'($urandom), 5'($urandom | $urandom));

        for (int k = 0; k < 6; k++) idle(1'b0, 8'hFF, 5'h1F);
        check("a_drained", 32'(qa.size()), 32'd0);
        check("b_drained", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
